io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 The block SHALL have parameter DRAM_AW, default 14, meaning the DRAM word-address width.
REQ-002 The block SHALL have parameter PSC_W, default 16, meaning the timer prescaler width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: cpu_clk in 1, the single clock; cpu_rst in 1, the asynchronous active-low reset.
REQ-004 The block SHALL have the port Bus_addr in 32, the CPU byte address.
REQ-005 The block SHALL have the port Bus_we in 1, the CPU write strobe (word granularity; the CPU has already merged byte and halfword data).
REQ-006 The block SHALL have the port Bus_wdata in 32, the CPU write data.
REQ-007 The block SHALL have the port Bus_rdata out 32, the read data returned to the CPU.
REQ-008 The block SHALL have the ports dram_addr out DRAM_AW, dram_we out 1, dram_wdata out 32 and dram_rdata in 32, forming the DRAM port with asynchronous read.
REQ-009 The block SHALL have the port sw in 24, the raw board switch inputs.
REQ-010 The block SHALL have the ports led out 24 (LED register) and dig_data out 32 (7-segment display value register).
REQ-011 The block SHALL have the port tmr_irq out 1, the timer match flag level.

Function
REQ-012 Decode SHALL be as follows:
- Bus_addr[31:12] == 20'hFFFFF selects the IO space.
- All other addresses select DRAM.
REQ-013 The IO register offsets (Bus_addr[11:0]) SHALL be:
- 0x000 DIG (RW)
- 0x020 TMR_CNT (RO)
- 0x024 TMR_CMP (RW)
- 0x028 TMR_CTRL (RW)
- 0x02C TMR_PSC (RW)
- 0x060 LED (RW)
- 0x070 SW (RO)
REQ-014 The DRAM port SHALL be driven as:
- dram_addr = Bus_addr[DRAM_AW+1:2].
- dram_wdata = Bus_wdata.
- dram_we = Bus_we AND DRAM selected.
REQ-015 Bus_rdata SHALL be purely combinational from Bus_addr in the same cycle, with zero latency, so that CPU byte/halfword read-modify-write stores work.
REQ-016 A read of an unmapped IO offset SHALL return 32'h0, and a write to it SHALL have no effect.
REQ-017 IO register writes SHALL take effect at the rising cpu_clk edge where Bus_we=1, and SHALL be visible on read in the next cycle.
REQ-018 LED SHALL store Bus_wdata[23:0] and drive led directly; DIG SHALL store the full 32 bits and drive dig_data directly.
REQ-019 SW SHALL read as {8'h0, sw synchronized through 2 flops}, giving a 2-cycle input-to-readable latency.
REQ-020 TMR_CTRL SHALL have these fields:
- bit0 EN (RW).
- bit1 AUTO (RW).
- bit2 FLAG (read; write-1-to-clear).
- All other bits read 0.
REQ-021 With EN=1, the PSC_W-bit prescaler counter SHALL count 0..TMR_PSC. On each terminal count it SHALL wrap to 0 and increment TMR_CNT by 1. TMR_PSC=0 therefore means TMR_CNT increments every cycle.
REQ-022 When TMR_CNT == TMR_CMP at a tick, the block SHALL set FLAG on that tick. In the same tick:
- if AUTO=1, TMR_CNT SHALL load 0;
- if AUTO=0, TMR_CNT SHALL hold at TMR_CMP and EN SHALL clear (one-shot).
REQ-023 TMR_CNT SHALL wrap from 32'hFFFFFFFF to 0 with no side effects when there is no match.
REQ-024 A write to TMR_CMP or TMR_PSC SHALL clear both the prescaler counter and TMR_CNT at that edge.
REQ-025 If a FLAG set and a FLAG write-1-clear occur in the same cycle, the set SHALL win.
REQ-026 A CTRL write that also sets EN=1 SHALL NOT reset the counters. A match event in that same cycle SHALL override only the EN bit written.
REQ-027 With EN=0, the prescaler counter and TMR_CNT SHALL hold their values.
REQ-028 tmr_irq SHALL equal FLAG and SHALL be a registered level.

Reset
REQ-029 Asserting cpu_rst low SHALL asynchronously clear to 0, including mid-count:
- LED, DIG, TMR_CNT, TMR_CMP, TMR_CTRL, TMR_PSC;
- the prescaler counter and the SW synchronizer.
REQ-030 During reset, led=0, dig_data=0 and tmr_irq=0. dram_we SHALL follow REQ-014 combinationally.
REQ-031 Deassertion of cpu_rst SHALL be followed by normal operation from the first rising edge.

Configuration
REQ-032 The macro IO_BRIDGE_TIMER_EN SHALL control the timer:
- Defined: the timer registers and logic are present per REQ-020..REQ-028.
- Undefined: no timer logic is synthesized; offsets 0x020-0x02C read 0 and ignore writes; tmr_irq is tied to 0.

Verification
REQ-033 Write 32'h12345678 to 0xFFFFF000 -> dig_data=32'h12345678 next cycle, and a read of 0xFFFFF000 returns it; dram_we stays 0.
REQ-034 Write 32'hDEADBEEF to 0x00000104 -> dram_we=1 and dram_addr=14'h041 in that cycle; with dram_rdata driven to 32'hDEADBEEF, a read of 0x104 returns the same value combinationally.
REQ-035 Program PSC=1, CMP=3, CTRL=3 (EN, AUTO) -> TMR_CNT steps 0,1,2,3 every 2 cycles; FLAG/tmr_irq rises on the 3 match; TMR_CNT reloads to 0 and repeats every 8 cycles.
REQ-036 Program CMP=2, PSC=0, CTRL=1 (one-shot) -> TMR_CNT halts at 2, EN reads 0, FLAG=1. Write CTRL=4 -> FLAG clears. Issue the clear in the same cycle as a match -> FLAG stays 1.
REQ-037 Change sw to 24'hA5A5A5 -> a read of 0xFFFFF070 returns 32'h00A5A5A5 no earlier than 2 edges later.
REQ-038 Assert cpu_rst low mid-count with LED=24'hFFFFFF -> led, TMR_CNT and tmr_irq are 0 immediately, without a clock edge. Repeat with IO_BRIDGE_TIMER_EN undefined -> offset 0x020 reads 0 and tmr_irq=0 at all times.

Source files
------------

// File: rtl/io_bridge.sv
// ============================================================================
// Module   : io_bridge
// Purpose  : CPU bus bridge decoding DRAM and memory-mapped IO (DIG, LED, SW,
//            timer).
//            The timer is built only when IO_BRIDGE_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bridge #(
    parameter int DRAM_AW = 14,
    parameter int PSC_W   = 16
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_we,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [31:0]        dig_data,
    output logic               tmr_irq
);

    localparam logic [19:0] c_io_page  = 20'hFFFFF;
    localparam logic [11:0] c_off_dig  = 12'h000;
    localparam logic [11:0] c_off_cnt  = 12'h020;
    localparam logic [11:0] c_off_cmp  = 12'h024;
    localparam logic [11:0] c_off_ctrl = 12'h028;
    localparam logic [11:0] c_off_psc  = 12'h02C;
    localparam logic [11:0] c_off_led  = 12'h060;
    localparam logic [11:0] c_off_sw   = 12'h070;

    logic        w_io_sel;
    logic [11:0] w_off;
    logic        w_io_we;

    assign w_io_sel = (Bus_addr[31:12] == c_io_page);
    assign w_off    = Bus_addr[11:0];
    assign w_io_we  = Bus_we & w_io_sel;

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_wdata = Bus_wdata;
    assign dram_we    = Bus_we & ~w_io_sel;

    logic [23:0] r_led;
    logic [31:0] r_dig;
    logic [23:0] r_sw_meta;
    logic [23:0] r_sw_sync;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_led     <= '0;
            r_dig     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_io_we && (w_off == c_off_led))
                r_led <= Bus_wdata[23:0];
            if (w_io_we && (w_off == c_off_dig))
                r_dig <= Bus_wdata;
        end
    end

    assign led      = r_led;
    assign dig_data = r_dig;

    // Timer view shared by the read mux; tied to zero when the timer is absent.
    logic [31:0]      w_tmr_cnt;
    logic [31:0]      w_tmr_cmp;
    logic [PSC_W-1:0] w_tmr_psc;
    logic [2:0]       w_tmr_ctrl;

`ifdef IO_BRIDGE_TIMER_EN
    logic [PSC_W-1:0] r_psc_cnt;
    logic [PSC_W-1:0] r_tmr_psc;
    logic [31:0]      r_tmr_cnt;
    logic [31:0]      r_tmr_cmp;
    logic             r_en;
    logic             r_auto;
    logic             r_flag;

    logic w_wr_cmp;
    logic w_wr_psc;
    logic w_wr_ctrl;
    logic w_tick;
    logic w_match;

    assign w_wr_cmp  = w_io_we && (w_off == c_off_cmp);
    assign w_wr_psc  = w_io_we && (w_off == c_off_psc);
    assign w_wr_ctrl = w_io_we && (w_off == c_off_ctrl);
    assign w_tick    = r_en && (r_psc_cnt == r_tmr_psc);
    assign w_match   = w_tick && (r_tmr_cnt == r_tmr_cmp);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_psc_cnt <= '0;
            r_tmr_psc <= '0;
            r_tmr_cnt <= '0;
            r_tmr_cmp <= '0;
            r_en      <= 1'b0;
            r_auto    <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            if (w_wr_cmp)
                r_tmr_cmp <= Bus_wdata;
            if (w_wr_psc)
                r_tmr_psc <= Bus_wdata[PSC_W-1:0];
            if (w_wr_ctrl) begin
                r_en   <= Bus_wdata[0];
                r_auto <= Bus_wdata[1];
                if (Bus_wdata[2])
                    r_flag <= 1'b0;
            end
            // Placed after the CTRL write so a match overrides the written EN
            // and a simultaneous FLAG set beats the write-1-clear.
            if (w_match) begin
                r_flag <= 1'b1;
                if (!r_auto)
                    r_en <= 1'b0;
            end

            if (w_wr_cmp || w_wr_psc) begin
                r_psc_cnt <= '0;
                r_tmr_cnt <= '0;
            end else if (w_tick) begin
                r_psc_cnt <= '0;
                if (!w_match)
                    r_tmr_cnt <= r_tmr_cnt + 32'd1;
                else if (r_auto)
                    r_tmr_cnt <= '0;
            end else if (r_en) begin
                r_psc_cnt <= r_psc_cnt + {{(PSC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_tmr_cnt  = r_tmr_cnt;
    assign w_tmr_cmp  = r_tmr_cmp;
    assign w_tmr_psc  = r_tmr_psc;
    assign w_tmr_ctrl = {r_flag, r_auto, r_en};
    assign tmr_irq    = r_flag;
`else
    assign w_tmr_cnt  = '0;
    assign w_tmr_cmp  = '0;
    assign w_tmr_psc  = '0;
    assign w_tmr_ctrl = '0;
    assign tmr_irq    = 1'b0;
`endif

    // Zero-latency read path: CPU partial stores rely on same-cycle data.
    always_comb begin
        Bus_rdata = dram_rdata;
        if (w_io_sel) begin
            case (w_off)
                c_off_dig:  Bus_rdata = r_dig;
                c_off_cnt:  Bus_rdata = w_tmr_cnt;
                c_off_cmp:  Bus_rdata = w_tmr_cmp;
                c_off_ctrl: Bus_rdata = {29'd0, w_tmr_ctrl};
                c_off_psc:  Bus_rdata = 32'(w_tmr_psc);
                c_off_led:  Bus_rdata = {8'h00, r_led};
                c_off_sw:   Bus_rdata = {8'h00, r_sw_sync};
                default:    Bus_rdata = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_bridge.sv
// ============================================================================
// Module   : tb_io_bridge
// Purpose  : Directed self-checking bench for io_bridge; timer checks follow
//            IO_BRIDGE_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_bridge;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [31:0] dig_data;
    logic        tmr_irq;

    int n_checks = 0;
    int n_fail   = 0;

    io_bridge #(.DRAM_AW(14), .PSC_W(16)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .dig_data   (dig_data),
        .tmr_irq    (tmr_irq)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Bus_addr  = addr;
        Bus_wdata = data;
        Bus_we    = 1'b1;
        @(negedge cpu_clk);
        Bus_we    = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Bus_addr = addr;
        Bus_we   = 1'b0;
        #1;
        check(tag, Bus_rdata, exp);
    endtask

    initial begin
        cpu_rst    = 1'b0;
        Bus_addr   = 32'h0;
        Bus_we     = 1'b0;
        Bus_wdata  = 32'h0;
        dram_rdata = 32'h0;
        sw         = 24'h0;

        #2;
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_dig", dig_data, 32'h0);
        check("rst_irq", {31'h0, tmr_irq}, 32'h0);

        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);

        // DIG write and readback; no DRAM strobe for IO space
        Bus_addr  = 32'hFFFF_F000;
        Bus_wdata = 32'h1234_5678;
        Bus_we    = 1'b1;
        #1;
        check("dig_dram_we", {31'h0, dram_we}, 32'h0);
        @(negedge cpu_clk);
        Bus_we = 1'b0;
        check("dig_out", dig_data, 32'h1234_5678);
        read_chk("dig_rd", 32'hFFFF_F000, 32'h1234_5678);

        // DRAM write strobe, address and data
        Bus_addr  = 32'h0000_0104;
        Bus_wdata = 32'hDEAD_BEEF;
        Bus_we    = 1'b1;
        #1;
        check("dram_we", {31'h0, dram_we}, 32'h1);
        check("dram_addr", {18'h0, dram_addr}, 32'h0000_0041);
        check("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
        @(negedge cpu_clk);
        Bus_we     = 1'b0;
        dram_rdata = 32'hDEAD_BEEF;
        read_chk("dram_rd", 32'h0000_0104, 32'hDEAD_BEEF);
        dram_rdata = 32'h0BAD_F00D;
        read_chk("dram_rd_comb", 32'h0000_0104, 32'h0BAD_F00D);

        // LED keeps only the low 24 bits
        bus_write(32'hFFFF_F060, 32'hAAFF_FFFF);
        check("led_out", {8'h0, led}, 32'h00FF_FFFF);
        read_chk("led_rd", 32'hFFFF_F060, 32'h00FF_FFFF);

        // Unmapped offset: reads 0, write has no effect elsewhere
        bus_write(32'hFFFF_F004, 32'h5555_5555);
        read_chk("unmapped_rd", 32'hFFFF_F004, 32'h0);
        read_chk("unmapped_dig", 32'hFFFF_F000, 32'h1234_5678);

        // Switch synchronizer latency
        sw = 24'hA5A5A5;
        @(negedge cpu_clk);
        read_chk("sw_1edge", 32'hFFFF_F070, 32'h0);
        @(negedge cpu_clk);
        read_chk("sw_2edge", 32'hFFFF_F070, 32'h00A5_A5A5);

`ifdef IO_BRIDGE_TIMER_EN
        // Auto-reload: PSC=1, CMP=3, EN|AUTO
        bus_write(32'hFFFF_F02C, 32'h1);
        bus_write(32'hFFFF_F024, 32'h3);
        bus_write(32'hFFFF_F028, 32'h3);
        for (int k = 0; k < 10; k++) begin
            read_chk($sformatf("auto_cnt%0d", k), 32'hFFFF_F020, 32'((k / 2) % 4));
            check($sformatf("auto_irq%0d", k), {31'h0, tmr_irq}, (k >= 8) ? 32'h1 : 32'h0);
            @(negedge cpu_clk);
        end

        // One-shot: CMP=2, PSC=0, EN
        bus_write(32'hFFFF_F028, 32'h4);
        check("ctrl_clr_irq", {31'h0, tmr_irq}, 32'h0);
        bus_write(32'hFFFF_F024, 32'h2);
        bus_write(32'hFFFF_F02C, 32'h0);
        bus_write(32'hFFFF_F028, 32'h1);
        repeat (5) @(negedge cpu_clk);
        read_chk("oneshot_cnt", 32'hFFFF_F020, 32'h2);
        read_chk("oneshot_ctrl", 32'hFFFF_F028, 32'h4);
        check("oneshot_irq", {31'h0, tmr_irq}, 32'h1);
        bus_write(32'hFFFF_F028, 32'h4);
        read_chk("w1c_ctrl", 32'hFFFF_F028, 32'h0);
        check("w1c_irq", {31'h0, tmr_irq}, 32'h0);

        // Clear issued on the match edge: set wins
        bus_write(32'hFFFF_F024, 32'h2);
        bus_write(32'hFFFF_F028, 32'h1);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        bus_write(32'hFFFF_F028, 32'h4);
        read_chk("setwin_ctrl", 32'hFFFF_F028, 32'h4);
        read_chk("setwin_cnt", 32'hFFFF_F020, 32'h2);
        check("setwin_irq", {31'h0, tmr_irq}, 32'h1);

        // Free-running count before the reset test
        bus_write(32'hFFFF_F024, 32'd100);
        bus_write(32'hFFFF_F028, 32'h3);
        repeat (5) @(negedge cpu_clk);
        read_chk("run_cnt", 32'hFFFF_F020, 32'd5);
`else
        bus_write(32'hFFFF_F024, 32'h5);
        bus_write(32'hFFFF_F02C, 32'h0);
        bus_write(32'hFFFF_F028, 32'h7);
        repeat (4) @(negedge cpu_clk);
        read_chk("notmr_cnt", 32'hFFFF_F020, 32'h0);
        read_chk("notmr_cmp", 32'hFFFF_F024, 32'h0);
        read_chk("notmr_ctrl", 32'hFFFF_F028, 32'h0);
        read_chk("notmr_psc", 32'hFFFF_F02C, 32'h0);
        check("notmr_irq", {31'h0, tmr_irq}, 32'h0);
`endif

        // Asynchronous reset between clock edges
        Bus_addr = 32'hFFFF_F020;
        #2;
        cpu_rst = 1'b0;
        #1;
        check("arst_led", {8'h0, led}, 32'h0);
        check("arst_dig", dig_data, 32'h0);
        check("arst_irq", {31'h0, tmr_irq}, 32'h0);
        check("arst_cnt", Bus_rdata, 32'h0);

        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
